// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback over one shared memory port.
// Optional PERF_COUNTERS_EN adds cycle_count and instret_count outputs.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] imm_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       retire,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [2:0] state_o
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
`endif
);

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_R   = 7'b0110011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_DEC = 2'b10;

    localparam int             TW     = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0]  T_LAST = TW'(MEM_TIMEOUT - 1);

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] imm_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       wb_sel;
        logic       retire;
    } ctrl_t;

    logic [2:0]    state, next_state;
    logic [TW-1:0] wait_cnt;
    ctrl_t         c;
    logic          is_lw, is_i, is_sw, is_beq, is_r, supported, timeout, waiting;
    logic [1:0]    dec_imm;

    // funct fields are consumed by the datapath's ALU decoder, not here
    logic unused_funct;
    assign unused_funct = ^{funct3, funct7b5};

    assign is_lw     = (opcode == OP_LW);
    assign is_i      = (opcode == OP_I);
    assign is_sw     = (opcode == OP_SW);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_r      = (opcode == OP_R);
    assign supported = is_lw | is_i | is_sw | is_beq | is_r;
    assign waiting   = (state == S_FETCH) || (state == S_MEM);
    // a ready in the last allowed cycle still completes normally
    assign timeout   = (wait_cnt == T_LAST) && !mem_ready;

    always_comb begin
        dec_imm = 2'b11;
        if (is_lw || is_i) dec_imm = 2'b00;
        else if (is_sw)    dec_imm = 2'b01;
        else if (is_beq)   dec_imm = 2'b10;
    end

    always_comb begin
        c          = '0;
        next_state = state;
        case (state)
            S_BOOT: next_state = S_FETCH;
            S_FETCH: begin
                c.mem_req = 1'b1;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state = S_FAULT;
                end
            end
            S_DECODE: begin
                c.imm_sel  = dec_imm;
                next_state = supported ? S_EXEC : S_FAULT;
            end
            S_EXEC: begin
                c.imm_sel = dec_imm;
                if (is_lw || is_sw) begin
                    c.alu_src  = 1'b1;
                    c.alu_op   = ALU_ADD;
                    next_state = S_MEM;
                end else if (is_i) begin
                    c.alu_src  = 1'b1;
                    c.alu_op   = ALU_DEC;
                    next_state = S_WB;
                end else if (is_r) begin
                    c.alu_op   = ALU_DEC;
                    next_state = S_WB;
                end else if (is_beq) begin
                    c.alu_op   = ALU_SUB;
                    c.pc_write = zero;
                    c.pc_src   = 1'b1;
                    c.retire   = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_MEM: begin
                c.mem_req      = 1'b1;
                c.mem_addr_sel = 1'b1;
                c.mem_we       = is_sw;
                c.alu_src      = 1'b1;
                c.alu_op       = ALU_ADD;
                if (mem_ready) begin
                    if (is_sw) begin
                        c.retire   = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (timeout) begin
                    next_state = S_FAULT;
                end
            end
            S_WB: begin
                c.reg_write = 1'b1;
                c.wb_sel    = is_lw;
                c.retire    = 1'b1;
                next_state  = S_FETCH;
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_BOOT;
            wait_cnt      <= '0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if ((state == S_DECODE || state == S_EXEC) && !supported)
                illegal_instr <= 1'b1;
            if (waiting && timeout)
                bus_error <= 1'b1;
        end
    end

    assign mem_req      = c.mem_req;
    assign mem_we       = c.mem_we;
    assign mem_addr_sel = c.mem_addr_sel;
    assign ir_write     = c.ir_write;
    assign pc_write     = c.pc_write;
    assign pc_src       = c.pc_src;
    assign imm_sel      = c.imm_sel;
    assign alu_src      = c.alu_src;
    assign alu_op       = c.alu_op;
    assign reg_write    = c.reg_write;
    assign wb_sel       = c.wb_sel;
    assign retire       = c.retire;
    assign state_o      = state;

`ifdef PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (state != S_BOOT && state != S_FAULT)
                cycle_count <= cycle_count + 1'b1;
            if (c.retire)
                instret_count <= instret_count + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
